// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA copy engine.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a. Build option DMA_ERR_EN adds the ABORT state.
package dma_pkg;

`ifdef DMA_ERR_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2,
    ABORT  = 2'd3
  } dma_state_e;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } dma_state_e;
`endif

  // Bytes per word and address shift for the default 32-bit datapath.
  localparam int BYTES      = 4;
  localparam int BYTE_SHIFT = 2;

  // Width able to hold every value 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // log2 of bytes per word for a given data width.
  function automatic int byte_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Synchronous FIFO: read-data buffer between the read and write channels.
// Latency: a push becomes visible on dout/empty the cycle after it is written.
// Backpressure: push ignored when full unless a pop occurs in the same cycle.
//
// Ports: clk/rst (async active-high), clr (synchronous flush), push/din,
//        pop, dout (head entry), full, empty, count (0..DEPTH).
module dma_sync_fifo
  import dma_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok  = push && (!full || pop_ok);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dma_copy_engine.sv
// Word-by-word memory copy engine fed by the register block (start/addresses/length).
// Latency: first read request 1 cycle after start; read response to write request 1 cycle.
// Backpressure: reads stall while buffered + outstanding words reach FIFO_DEPTH; valids held until ready.
//
// Ports: ACLK, ARESET (async active-high); start, irq_enable, src_addr, dst_addr,
//        length (bytes) in; busy, done (sticky), irq (1-cycle pulse) out;
//        rd_req_* / rd_resp_* read channel; wr_req_* / wr_resp_valid write channel.
// Build option DMA_ERR_EN: adds rd_resp_err, wr_resp_err inputs and sticky error output.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic                  irq_enable,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  irq,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic                  rd_resp_valid,
  input  logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic                  wr_resp_valid
`ifdef DMA_ERR_EN
  ,
  input  logic                  rd_resp_err,
  input  logic                  wr_resp_err,
  output logic                  error
`endif
);

  localparam int WORD_BYTES = DATA_WIDTH / 8;
  localparam int WORD_SHIFT = byte_shift(DATA_WIDTH);
  localparam int CW         = cnt_width(FIFO_DEPTH);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(WORD_BYTES);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [CW:0]           DEPTH_C   = (CW + 1)'(FIFO_DEPTH);

  dma_state_e            state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  irq_en_q, irq_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [LEN_WIDTH-1:0]  words_q, words_d;
  logic [LEN_WIDTH-1:0]  rd_issued_q, rd_issued_d;
  logic [LEN_WIDTH-1:0]  wr_acks_q, wr_acks_d;
  logic [CW-1:0]         rd_out_q, rd_out_d;

  logic                  fifo_clr, fifo_push, fifo_pop;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] fifo_dout;

  logic                  active, rd_hs, wr_hs, rd_rsp, wr_rsp, rd_room;
  logic [CW:0]           inflight;
  logic [LEN_WIDTH-1:0]  len_words;

`ifdef DMA_ERR_EN
  logic                  error_q, error_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [LEN_WIDTH-1:0]  wr_issued_q, wr_issued_d;
  logic                  err_evt;

  assign error = error_q;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign rd_req_addr = rd_addr_q;
  assign wr_req_addr = wr_addr_q;
  assign wr_req_data = fifo_dout;

  dma_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .din   (rd_resp_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = done_q;
    irq_en_d     = irq_en_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    words_d      = words_q;
    rd_issued_d  = rd_issued_q;
    wr_acks_d    = wr_acks_q;
    rd_out_d     = rd_out_q;
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    irq          = 1'b0;
    fifo_clr     = 1'b0;
    len_words    = length >> WORD_SHIFT;
`ifdef DMA_ERR_EN
    error_d      = error_q;
    wr_issued_d  = wr_issued_q;
    err_evt      = 1'b0;
`endif

    // Every buffered word plus every read still in flight owns a FIFO slot,
    // so gating reads on this sum guarantees responses never find it full.
    inflight = {1'b0, fifo_count} + {1'b0, rd_out_q};
    rd_room  = !fifo_full && (inflight < DEPTH_C);

    case (state_q)
      RUN: begin
        rd_req_valid = (rd_issued_q < words_q) && rd_room;
        wr_req_valid = !fifo_empty;
      end
`ifdef DMA_ERR_EN
      // Only requests already presented but not yet accepted stay up.
      ABORT: begin
        rd_req_valid = rd_pend_q;
        wr_req_valid = wr_pend_q;
      end
`endif
      default: ;
    endcase

    active   = (state_q != IDLE) && (state_q != FINISH);
    rd_hs    = rd_req_valid && rd_req_ready;
    wr_hs    = wr_req_valid && wr_req_ready;
    rd_rsp   = rd_resp_valid && active;
    wr_rsp   = wr_resp_valid && active;
    fifo_pop = wr_hs;
`ifdef DMA_ERR_EN
    rd_pend_d = rd_req_valid && !rd_req_ready;
    wr_pend_d = wr_req_valid && !wr_req_ready;
    err_evt   = (rd_rsp && rd_resp_err) || (wr_rsp && wr_resp_err);
    if (err_evt) begin
      error_d = 1'b1;
    end
    // Read data is dropped once aborting, and never taken from a failed read.
    fifo_push = rd_rsp && (state_q == RUN) && !rd_resp_err;
`else
    fifo_push = rd_rsp;
`endif

    if (rd_hs) begin
      rd_addr_d   = rd_addr_q + ADDR_STEP;
      rd_issued_d = rd_issued_q + LEN_ONE;
    end
    if (wr_hs) begin
      wr_addr_d   = wr_addr_q + ADDR_STEP;
`ifdef DMA_ERR_EN
      wr_issued_d = wr_issued_q + LEN_ONE;
`endif
    end
    if (wr_rsp) begin
      wr_acks_d = wr_acks_q + LEN_ONE;
    end
    case ({rd_hs, rd_rsp})
      2'b10:   rd_out_d = rd_out_q + CNT_ONE;
      2'b01:   rd_out_d = rd_out_q - CNT_ONE;
      default: rd_out_d = rd_out_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          rd_addr_d   = src_addr;
          wr_addr_d   = dst_addr;
          words_d     = len_words;
          rd_issued_d = '0;
          wr_acks_d   = '0;
          rd_out_d    = '0;
          irq_en_d    = irq_enable;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fifo_clr    = 1'b1;
`ifdef DMA_ERR_EN
          wr_issued_d = '0;
          error_d     = 1'b0;
`endif
          state_d     = (len_words == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (wr_acks_d == words_q) begin
          state_d = FINISH;
        end
`ifdef DMA_ERR_EN
        if (err_evt) begin
          state_d = ABORT;
        end
`endif
      end
`ifdef DMA_ERR_EN
      ABORT: begin
        if (!rd_pend_q && !wr_pend_q && (rd_out_d == '0) && (wr_issued_d == wr_acks_d)) begin
          state_d = FINISH;
        end
      end
`endif
      FINISH: begin
        irq      = irq_en_q;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        fifo_clr = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      words_q     <= '0;
      rd_issued_q <= '0;
      wr_acks_q   <= '0;
      rd_out_q    <= '0;
`ifdef DMA_ERR_EN
      error_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_issued_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      irq_en_q    <= irq_en_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      words_q     <= words_d;
      rd_issued_q <= rd_issued_d;
      wr_acks_q   <= wr_acks_d;
      rd_out_q    <= rd_out_d;
`ifdef DMA_ERR_EN
      error_q     <= error_d;
      rd_pend_q   <= rd_pend_d;
      wr_pend_q   <= wr_pend_d;
      wr_issued_q <= wr_issued_d;
`endif
    end
  end

endmodule
